// File: rtl/atm_pkg.sv
// Shared types and key codes for the ATM keypad entry stage.
// Keypad FSM states, control key encodings and the decimal-shift helper.
package atm_pkg;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_ENTRY,
        KP_PRESENT
    } kp_state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;

    // bin*10 + d using shifts; a 4-digit entry never exceeds 9999
    function automatic logic [15:0] mul10_add(
        input logic [15:0] b,
        input logic [3:0]  d
    );
        return (b << 3) + (b << 1) + {12'd0, d};
    endfunction

endpackage

// File: rtl/atm_entry_timer.sv
// Inactivity counter for keypad entry.
// Counts enabled cycles; expire pulses when CYCLES-1 is reached without a clear.
module atm_entry_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(CYCLES);

    logic [CW-1:0] cnt;

    assign expire = en && !clr && (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry stage: accumulates PIN (BCD) or amount (binary) digits
// and presents the validated result over a valid/ready handshake.
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_en,
    input  logic        mode_amount,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] pin_bcd,
    output logic [15:0] amount_bin,
    output logic        out_is_amount,
    output logic        cancel_pulse,
    output logic        timeout_flag,
    output logic        entry_error,
    output logic [2:0]  digit_count
);

    kp_state_t   state, state_d;
    logic        mode_q;
    logic [15:0] bcd, bin;
    logic [2:0]  count;
    logic        cancel_d, tmo_d, err_d;
    logic        expire, is_digit, enter_ok;

    atm_entry_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state != KP_ENTRY) || key_valid),
        .en     (state == KP_ENTRY),
        .expire (expire)
    );

    assign is_digit = (key_code <= 4'd9);
    assign enter_ok = mode_q ? (bin != 16'd0)
                             : (count == 3'(MAX_DIGITS));

    always_comb begin
        state_d  = state;
        cancel_d = 1'b0;
        tmo_d    = 1'b0;
        err_d    = 1'b0;
        unique case (state)
            KP_IDLE: begin
                if (entry_en) state_d = KP_ENTRY;
            end
            KP_ENTRY: begin
                if (!entry_en) begin
                    state_d = KP_IDLE;
                end else if (key_valid) begin
                    unique case (1'b1)
                        (key_code == KEY_CANCEL): begin
                            cancel_d = 1'b1;
                            state_d  = KP_IDLE;
                        end
                        (key_code == KEY_ENTER): begin
                            if (enter_ok) state_d = KP_PRESENT;
                            else          err_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (expire) begin
                    cancel_d = 1'b1;
                    tmo_d    = 1'b1;
                    state_d  = KP_IDLE;
                end
            end
            KP_PRESENT: begin
                if (!entry_en || out_ready) state_d = KP_IDLE;
            end
            default: state_d = KP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= KP_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 1'b0;
            bcd          <= '0;
            bin          <= '0;
            count        <= '0;
            cancel_pulse <= 1'b0;
            timeout_flag <= 1'b0;
            entry_error  <= 1'b0;
        end else begin
            cancel_pulse <= cancel_d;
            timeout_flag <= tmo_d;
            entry_error  <= err_d;
            if (state == KP_IDLE && entry_en) mode_q <= mode_amount;
            if (state_d == KP_IDLE) begin
                bcd   <= '0;
                bin   <= '0;
                count <= '0;
            end else if (state == KP_ENTRY && key_valid) begin
                unique case (1'b1)
                    is_digit: begin
                        if (count < 3'(MAX_DIGITS)) begin
                            bcd   <= {bcd[11:0], key_code};
                            bin   <= mul10_add(bin, key_code);
                            count <= count + 3'd1;
                        end
                    end
                    (key_code == KEY_BACK): begin
                        if (count != 3'd0) begin
                            bcd   <= {4'h0, bcd[15:4]};
                            bin   <= bin / 16'd10;
                            count <= count - 3'd1;
                        end
                    end
                    (key_code == KEY_CLEAR): begin
                        bcd   <= '0;
                        bin   <= '0;
                        count <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid     = (state == KP_PRESENT);
    assign pin_bcd       = (out_valid && !mode_q) ? bcd : 16'd0;
    assign amount_bin    = (out_valid && mode_q)  ? bin : 16'd0;
    assign out_is_amount = out_valid && mode_q;
    assign digit_count   = count;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Self-checking bench for atm_keypad_entry.
// Vector table per cycle, plus hand sequences for timeout and reset.
module tb_atm_keypad_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        entry_en = 1'b0;
    logic        mode_amount = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] pin_bcd;
    logic [15:0] amount_bin;
    logic        out_is_amount;
    logic        cancel_pulse;
    logic        timeout_flag;
    logic        entry_error;
    logic [2:0]  digit_count;

    int n_chk  = 0;
    int n_fail = 0;

    atm_keypad_entry #(
        .MAX_DIGITS     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .entry_en      (entry_en),
        .mode_amount   (mode_amount),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .pin_bcd       (pin_bcd),
        .amount_bin    (amount_bin),
        .out_is_amount (out_is_amount),
        .cancel_pulse  (cancel_pulse),
        .timeout_flag  (timeout_flag),
        .entry_error   (entry_error),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        mode;
        logic        kv;
        logic [3:0]  key;
        logic        rdy;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [39:0] outs();
        return {out_valid, pin_bcd, amount_bin, out_is_amount,
                cancel_pulse, timeout_flag, entry_error, digit_count};
    endfunction

    task automatic add(
        input logic en, input logic mode, input logic kv,
        input logic [3:0] key, input logic rdy,
        input logic ov, input logic [15:0] pin, input logic [15:0] amt,
        input logic isa, input logic can, input logic tmo,
        input logic err, input logic [2:0] cnt
    );
        vec_t v;
        v.en   = en;
        v.mode = mode;
        v.kv   = kv;
        v.key  = key;
        v.rdy  = rdy;
        v.exp  = {ov, pin, amt, isa, can, tmo, err, cnt};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;

        // PIN 1234 with immediate accept
        add(1,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,0,1,4'h1,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,0,1,4'h2,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(1,0,1,4'h3,0, 0,16'h0,16'd0,0,0,0,0,3'd3);
        add(1,0,1,4'h4,0, 0,16'h0,16'd0,0,0,0,0,3'd4);
        add(1,0,1,4'hC,1, 1,16'h1234,16'd0,0,0,0,0,3'd4);
        add(1,0,0,4'h0,1, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(0,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        // amount 80, consumer stalls five cycles, keys ignored
        add(1,1,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,1,1,4'h8,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,1,1,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(1,1,1,4'hC,0, 1,16'h0,16'd80,1,0,0,0,3'd2);
        for (int i = 0; i < 5; i++)
            add(1,1,(i == 2),4'h5,0, 1,16'h0,16'd80,1,0,0,0,3'd2);
        add(1,1,0,4'h0,1, 0,16'h0,16'd0,0,0,0,0,3'd0);
        // edit: backspace, clear, overflow digit dropped
        add(1,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,0,1,4'h1,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,0,1,4'h2,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(1,0,1,4'hB,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,0,1,4'h9,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(1,0,1,4'hA,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,0,1,4'hB,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,0,1,4'h5,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,0,1,4'h6,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(1,0,1,4'h7,0, 0,16'h0,16'd0,0,0,0,0,3'd3);
        add(1,0,1,4'h8,0, 0,16'h0,16'd0,0,0,0,0,3'd4);
        add(1,0,1,4'h9,0, 0,16'h0,16'd0,0,0,0,0,3'd4);
        add(1,0,1,4'hC,0, 1,16'h5678,16'd0,0,0,0,0,3'd4);
        add(1,0,0,4'h0,1, 0,16'h0,16'd0,0,0,0,0,3'd0);
        // short PIN rejected, then cancel
        add(1,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,0,1,4'h1,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,0,1,4'h2,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(1,0,1,4'h3,0, 0,16'h0,16'd0,0,0,0,0,3'd3);
        add(1,0,1,4'hC,0, 0,16'h0,16'd0,0,0,0,1,3'd3);
        add(1,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd3);
        add(1,0,1,4'hD,0, 0,16'h0,16'd0,0,1,0,0,3'd0);
        add(1,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        // session drop: no cancel pulse
        add(1,0,1,4'h1,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,0,1,4'h2,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(0,0,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        // amount 9999, then zero amount rejected
        add(1,1,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,1,1,4'h9,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,1,1,4'h9,0, 0,16'h0,16'd0,0,0,0,0,3'd2);
        add(1,1,1,4'h9,0, 0,16'h0,16'd0,0,0,0,0,3'd3);
        add(1,1,1,4'h9,0, 0,16'h0,16'd0,0,0,0,0,3'd4);
        add(1,1,1,4'hC,1, 1,16'h0,16'd9999,1,0,0,0,3'd4);
        add(1,1,0,4'h0,1, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,1,0,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd0);
        add(1,1,1,4'h0,0, 0,16'h0,16'd0,0,0,0,0,3'd1);
        add(1,1,1,4'hC,0, 0,16'h0,16'd0,0,0,0,1,3'd1);

        idle(2);
        chk("reset_state", 64'(outs()), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            entry_en    = vecs[i].en;
            mode_amount = vecs[i].mode;
            key_valid   = vecs[i].kv;
            key_code    = vecs[i].key;
            out_ready   = vecs[i].rdy;
            idle(1);
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
        end
        key_valid = 1'b0;
        out_ready = 1'b0;

        // timeout: 16 cycles after last key
        key(4'h4);
        chk("pre_timeout_count", 64'(digit_count), 64'd2);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            idle(1);
            if (cancel_pulse) begin
                lat = i;
                break;
            end
        end
        chk("timeout_latency", 64'(lat), 64'd16);
        chk("timeout_flags", 64'({timeout_flag, entry_error, digit_count}),
            64'({1'b1, 1'b0, 3'd0}));
        idle(1);
        chk("timeout_pulse_len", 64'({cancel_pulse, timeout_flag}), 64'd0);
        key(4'h5);
        chk("reentry_after_timeout", 64'(digit_count), 64'd1);

        // key on the expiry cycle wins
        idle(15);
        key(4'h6);
        chk("key_wins_expiry",
            64'({cancel_pulse, timeout_flag, digit_count}),
            64'({1'b0, 1'b0, 3'd2}));
        idle(15);
        chk("no_early_timeout", 64'(cancel_pulse), 64'd0);
        idle(1);
        chk("second_timeout", 64'({cancel_pulse, timeout_flag}), 64'd3);

        // reset while result presented
        mode_amount = 1'b0;
        idle(1);
        key(4'h1);
        key(4'h2);
        key(4'h3);
        key(4'h4);
        key(4'hC);
        chk("present_before_rst", 64'({out_valid, pin_bcd}),
            64'({1'b1, 16'h1234}));
        rst = 1'b1;
        idle(1);
        chk("rst_in_present", 64'(outs()), 64'd0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
